// File: rtl/mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter
//   Round-robin arbiter sharing one 2:1 data mux between two valid/ready
//   requesters. A registered grant FSM drives the mux select; the data path
//   from requester to sink stays purely combinational.
//
//   Build option:
//     MUX2_ARB_PKT_LOCK_EN  when defined, a granted requester keeps the mux
//                           until it transfers a beat with in_last set, so
//                           multi-beat packets stay contiguous. When undefined,
//                           re-arbitration happens after every beat and
//                           in_last only feeds out_last.
// -----------------------------------------------------------------------------
module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [1:0]       in_last,
    output logic [1:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       grant
);

    // Encoding matches the one-hot grant for readability; 2'b11 is unused.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    state_t other_state;   // BUSY state of the requester not currently granted

    logic sel;             // mux select; equals the granted requester while busy
    logic last_grant;      // requester that completed the most recent transfer
    logic mid_pkt;         // a packet is in progress on the granted requester
    logic mid_pkt_next;
    logic other;           // index of the requester not currently granted
    logic transfer;        // a beat moves from the granted requester to the sink
    logic hold;            // the granted requester keeps the mux next cycle

    assign other       = ~sel;
    assign other_state = sel ? BUSY0 : BUSY1;
    assign transfer    = (state != IDLE) && in_valid[sel] && out_ready;

    // The data path follows sel in every state, including IDLE where sel
    // simply keeps its last value; the sink ignores it while out_valid is low.
    assign out_data = sel ? in_data1 : in_data0;
    assign out_last = in_last[sel];

`ifdef MUX2_ARB_PKT_LOCK_EN
    // The packet flag tracks the granted requester's beats: a non-last
    // transfer opens a packet, a last transfer closes it, stalls keep it.
    assign mid_pkt_next = transfer ? ~in_last[sel] : mid_pkt;

    // Packet-in-progress register; cleared by reset so a dropped packet
    // never leaves the arbiter locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_pkt <= 1'b0;
        end else begin
            mid_pkt <= mid_pkt_next;
        end
    end
`else
    // Without packet lock every beat is a complete transfer unit.
    assign mid_pkt      = 1'b0;
    assign mid_pkt_next = 1'b0;
`endif

    // The grant stays put on a stalled beat and for the rest of an open packet.
    // A stalled beat still asserts valid, so holding keeps sel and out_data
    // stable for the sink.
    assign hold = mid_pkt_next || (in_valid[sel] && !out_ready);

    // State register plus the select and round-robin history that ride with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next != IDLE) begin
                sel <= (state_next == BUSY1);
            end
            if (transfer) begin
                last_grant <= sel;
            end
        end
    end

    // Next-state logic: round-robin choice from IDLE, handover or hold while busy.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred when a branch leaves the state unchanged.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid == 2'b11) begin
                    // Tie goes to the requester that was not served last.
                    state_next = last_grant ? BUSY0 : BUSY1;
                end else if (in_valid[0]) begin
                    state_next = BUSY0;
                end else if (in_valid[1]) begin
                    state_next = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (hold) begin
                    state_next = state;
                end else if (in_valid[other]) begin
                    // Direct handover between busy states avoids an idle bubble.
                    state_next = other_state;
                end else if (in_valid[sel]) begin
                    state_next = state;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: grant, per-requester ready and muxed valid from the state.
    always_comb begin
        grant     = 2'b00;
        in_ready  = 2'b00;
        out_valid = 1'b0;
        unique case (state)
            BUSY0: begin
                grant       = 2'b01;
                in_ready[0] = out_ready;
                out_valid   = in_valid[0];
            end
            BUSY1: begin
                grant       = 2'b10;
                in_ready[1] = out_ready;
                out_valid   = in_valid[1];
            end
            default: begin
                grant     = 2'b00;
                in_ready  = 2'b00;
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//   Self-checking bench for mux2_rr_arbiter. Expected beats are queued as the
//   stimulus is driven; a negedge monitor pops one for every beat the sink
//   accepts. Directed checks cover reset, latency, handover, backpressure and
//   the packet-lock option (MUX2_ARB_PKT_LOCK_EN selects the expected order).
// -----------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [1:0]       in_last;
    logic [1:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic [1:0]       grant;

    typedef struct packed {
        logic [1:0]       grant;
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t sb_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [1:0] g, input logic l, input logic [WIDTH-1:0] d);
        beat_t b;
        b.grant = g;
        b.last  = l;
        b.data  = d;
        sb_q.push_back(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        in_valid  = 2'b00;
        in_last   = 2'b00;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beat_t e;
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e.data));
                check("beat_last", 32'(out_last), 32'(e.last));
                check("beat_grant", 32'(grant), 32'(e.grant));
            end
        end
    end

    // Watchdog: the sequence below is fixed-length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] t5_grant [4];
        int         k;

`ifdef MUX2_ARB_PKT_LOCK_EN
        t5_grant = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
        t5_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        // ---- 1: reset with both requesters valid, then first tie -> ch0
        rst_n     = 1'b0;
        in_valid  = 2'b11;
        in_data0  = '0;
        in_data1  = '0;
        in_last   = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_still_idle", 32'(grant), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_first_tie", 32'(grant), 32'h1);
        check("t1_out_valid", 32'(out_valid), 32'h1);
        check("t1_in_ready_stall", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        in_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_back_idle", 32'(grant), 32'h0);

        // ---- 2: single requester, one-cycle latency, back to IDLE
        @(posedge clk); #1;
        in_valid  = 2'b01;
        in_data0  = 8'hA5;
        in_last   = 2'b01;
        out_ready = 1'b1;
        expect_beat(2'b01, 1'b1, 8'hA5);
        @(negedge clk);
        check("t2_latency_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_out_valid", 32'(out_valid), 32'h1);
        check("t2_out_data", 32'(out_data), 32'hA5);
        check("t2_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_idle_grant", 32'(grant), 32'h0);

        // ---- 3: both valid, alternating beats with no bubbles
        do_reset();
        @(posedge clk); #1;
        in_valid  = 2'b11;
        in_data0  = 8'h10;
        in_data1  = 8'h20;
        in_last   = 2'b11;
        out_ready = 1'b1;
        expect_beat(2'b01, 1'b1, 8'h10);
        expect_beat(2'b10, 1'b1, 8'h20);
        expect_beat(2'b01, 1'b1, 8'h10);
        expect_beat(2'b10, 1'b1, 8'h20);
        @(negedge clk);
        check("t3_latency_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("t3_no_bubble", 32'(out_valid), 32'h1);
            check("t3_grant", 32'(grant), (i % 2 == 1) ? 32'h2 : 32'h1);
        end
        @(posedge clk); #1;
        in_valid = 2'b00;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // ---- 4: backpressure in BUSY1 holds grant and data, then hands over
        in_valid  = 2'b10;
        in_data0  = 8'h33;
        in_data1  = 8'h44;
        in_last   = 2'b11;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_grant", 32'(grant), 32'h2);
            check("t4_stall_data", 32'(out_data), 32'h44);
            check("t4_stall_ready", 32'(in_ready), 32'h0);
            check("t4_stall_valid", 32'(out_valid), 32'h1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        expect_beat(2'b10, 1'b1, 8'h44);
        @(negedge clk);
        check("t4_release_ready", 32'(in_ready), 32'h2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 2'b00;
        @(negedge clk);
        check("t4_handover", 32'(grant), 32'h1);
        @(posedge clk); #1;

        // ---- 5: ch0 three-beat packet while ch1 stays valid
        do_reset();
        k = 0;
        @(posedge clk); #1;
        in_valid  = 2'b11;
        in_data0  = 8'h50;
        in_data1  = 8'h60;
        in_last   = 2'b10;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_latency_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_data0   = 8'(8'h50 + k);
            in_last[0] = (k == 2);
            if (t5_grant[i] == 2'b10) begin
                expect_beat(2'b10, 1'b1, 8'h60);
            end else begin
                expect_beat(2'b01, (k == 2), 8'(8'h50 + k));
            end
            @(negedge clk);
            check("t5_grant", 32'(grant), 32'(t5_grant[i]));
            if (t5_grant[i] == 2'b01) begin
                k++;
            end
        end
        @(posedge clk); #1;
        in_valid = 2'b00;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // ---- 6: reset in the middle of a ch0 packet
        do_reset();
        @(posedge clk); #1;
        in_valid  = 2'b01;
        in_data0  = 8'h70;
        in_last   = 2'b00;
        out_ready = 1'b1;
        expect_beat(2'b01, 1'b0, 8'h70);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        in_data0 = 8'h71;
        expect_beat(2'b01, 1'b0, 8'h71);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        in_valid  = 2'b11;
        out_ready = 1'b0;
        #1;
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_in_ready", 32'(in_ready), 32'h0);
        check("t6_rst_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_first_tie", 32'(grant), 32'h1);
        @(posedge clk); #1;
        in_valid = 2'b10;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_mid_pkt_clear", 32'(grant), 32'h2);
        @(posedge clk); #1;
        in_valid = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("end_idle", 32'(grant), 32'h0);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
